fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Keeps the PC and issues in-order word requests to instruction memory.
- Buffers returned words in a small FIFO and presents {instruction, PC} to the decoder over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- FIFO_DEPTH, 2: instruction buffer entries; power of two, >= 2. Also caps outstanding requests.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- inRst  in  1  asynchronous active-low reset.
- oMemReq  out  1  fetch request valid.
- oMemAddr  out  32  fetch word address (byte address, [1:0]=0).
- iMemGnt  in  1  request accepted this cycle (handshake = oMemReq & iMemGnt).
- iMemRValid  in  1  read data valid; responses return in request order, latency >= 1.
- iMemRData  in  32  read instruction word.
- iRedirect  in  1  redirect pulse from execute.
- iRedirectPC  in  32  redirect target.
- oINS  out  32  instruction to decoder.
- oPC  out  32  PC of oINS.
- oValid  out  1  oINS/oPC valid.
- iReady  in  1  decoder accepts (transfer = oValid & iReady).
- oMisalign  out  1  misaligned-fetch exception flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, FIFO empty, outstanding=0, drop=0.
  - Outputs on reset: oMemReq=0, oMemAddr=RESET_PC, oValid=0, oINS=0, oPC=0, oMisalign=0.
  - Reset mid-transaction discards everything; responses arriving after release for pre-reset requests are the memory's responsibility (memory is reset by the same signal).
- State:
  - PC (next address to request).
  - outstanding count (0..FIFO_DEPTH).
  - drop count (stale responses still to discard).
  - FIFO of {addr, data}.
  - Request-address queue of depth FIFO_DEPTH, tagging each request with its PC.
- Issue:
  - oMemReq = !iRedirect & (occupancy + outstanding < FIFO_DEPTH).
  - oMemAddr = PC.
  - On grant: PC += 4 (wraps modulo 2^32, 32'hFFFF_FFFC -> 0), outstanding++.
- Response:
  - iMemRValid with drop>0: word discarded, drop--, outstanding--.
  - Otherwise: push {tagged PC, iMemRData} into FIFO, outstanding--.
  - Credit rule guarantees the FIFO is never full on a push. A response with outstanding=0 is a protocol error; ignore it (assertion in bench).
- Output:
  - oValid = FIFO non-empty; oINS/oPC = FIFO head, combinational from storage (no extra latency).
  - Pop on oValid & iReady. Push and pop in the same cycle are both allowed; when full, pop frees a slot for credit the next cycle.
  - Minimum latency is grant -> memory latency -> same cycle the FIFO is written, visible on oValid the next cycle.
- Redirect (priority over every other event in that cycle):
  - PC <= iRedirectPC; FIFO flushed; oValid=0 next cycle.
  - drop <= outstanding_after_this_cycle, counting a grant in the redirect cycle is not possible (oMemReq forced 0) but counting any response in the redirect cycle as consumed.
  - Decoder pop in the redirect cycle is still honoured (the instruction was taken).
  - Back-to-back redirects: last one wins, drop accumulates correctly.
- Throughput: with 1-cycle memory, iMemGnt=1, iReady=1, FIFO_DEPTH=2 sustains 1 instruction/cycle.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with iRedirectPC[1:0]!=0 sets a sticky trap state: no requests issue, FIFO flushed.
  - oMisalign=1, oValid=1, oPC=target, oINS=32'h0000_0013 (NOP) until consumed.
  - After the handshake, the block stalls (oValid=0) until the next redirect clears the state.
- Undefined: oMisalign tied 0; iRedirectPC[1:0] ignored (forced to 0).

Test Plan:
- Reset with RESET_PC=32'h100, 1-cycle memory, iReady=1 -> oMemAddr 0x100,0x104,0x108 on consecutive cycles; oPC follows with matching words, oValid stays high.
- iReady=0 for 5 cycles -> at most FIFO_DEPTH grants, then oMemReq=0; release -> oPC order intact, no word lost or duplicated.
- 3-cycle memory latency, 2 requests outstanding, iRedirect to 0x400 -> both stale responses dropped; first oPC=0x400 with data from address 0x400.
- Redirect in the same cycle as decoder pop and response arrival -> popped instruction counted once, response dropped, oMemReq=0 that cycle.
- PC at 0xFFFF_FFFC -> next request address 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x202 -> oMisalign=1, oPC=0x202, oINS=0x13, no oMemReq until redirect to 0x300 resumes fetch.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order memory requests, response FIFO and redirect flush.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        iClk,
    input  logic        inRst,
    output logic        oMemReq,
    output logic [31:0] oMemAddr,
    input  logic        iMemGnt,
    input  logic        iMemRValid,
    input  logic [31:0] iMemRData,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic [31:0] oINS,
    output logic [31:0] oPC,
    output logic        oValid,
    input  logic        iReady,
    output logic        oMisalign
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic          run_q;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] tw_q, tr_q;
    logic [31:0]   fifo_pc  [FIFO_DEPTH];
    logic [31:0]   fifo_ins [FIFO_DEPTH];
    logic [31:0]   tag_pc   [FIFO_DEPTH];

    logic [CW-1:0] occ;
    logic [CW:0]   credit_used;
    logic          fifo_empty, fifo_full;
    logic          grant, resp, push, pop;
    logic          trap_block;
    logic [31:0]   target;
    logic [31:0]   head_pc, head_ins;

    assign occ        = wptr_q - rptr_q;
    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == FULL_C);
    assign head_pc    = fifo_pc[rptr_q[AW-1:0]];
    assign head_ins   = fifo_ins[rptr_q[AW-1:0]];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic trap_vld_q, trap_vld_d;

    assign target     = iRedirectPC;
    assign trap_block = trap_q;

    always_comb begin
        trap_d     = trap_q;
        trap_vld_d = trap_vld_q;
        if (iRedirect) begin
            trap_d     = |iRedirectPC[1:0];
            trap_vld_d = |iRedirectPC[1:0];
        end else if (trap_vld_q && iReady) begin
            trap_vld_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            trap_q     <= 1'b0;
            trap_vld_q <= 1'b0;
        end else begin
            trap_q     <= trap_d;
            trap_vld_q <= trap_vld_d;
        end
    end

    // The trap presents a NOP at the faulting target; pc_q holds that target while trapped.
    assign oMisalign = trap_vld_q;
    assign oValid    = trap_q ? trap_vld_q : !fifo_empty;
    assign oPC       = trap_q ? pc_q : head_pc;
    assign oINS      = trap_q ? 32'h0000_0013 : head_ins;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^iRedirectPC[1:0];
    assign target              = {iRedirectPC[31:2], 2'b00};
    assign trap_block          = 1'b0;
    assign oMisalign           = 1'b0;
    assign oValid              = !fifo_empty;
    assign oPC                 = head_pc;
    assign oINS                = head_ins;
`endif

    assign pop = !fifo_empty && iReady && !trap_block;

    // A same-cycle pop lends its slot to this cycle's request, except when the FIFO is full.
    assign credit_used = {1'b0, occ} + {1'b0, out_q} - {{CW{1'b0}}, pop && !fifo_full};

    assign oMemReq  = run_q && !iRedirect && !trap_block && (credit_used < DEPTH_C);
    assign oMemAddr = pc_q;

    assign grant = oMemReq && iMemGnt;
    assign resp  = iMemRValid && (out_q != '0);
    assign push  = resp && !iRedirect && (drop_q == '0) && !trap_block;

    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(grant) - CW'(resp);
        drop_d = drop_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (grant) pc_d = pc_q + 32'd4;
        if (push) wptr_d = wptr_q + CW'(1);
        if (pop) rptr_d = rptr_q + CW'(1);
        if (resp && drop_q != '0) drop_d = drop_q - CW'(1);
        // Redirect wins: everything still in flight after this cycle becomes stale.
        if (iRedirect) begin
            pc_d   = target;
            drop_d = out_q - CW'(resp);
            wptr_d = wptr_q;
            rptr_d = wptr_q;
        end
    end

    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            pc_q   <= RESET_PC;
            run_q  <= 1'b0;
            out_q  <= '0;
            drop_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            tw_q   <= '0;
            tr_q   <= '0;
        end else begin
            pc_q   <= pc_d;
            run_q  <= 1'b1;
            out_q  <= out_d;
            drop_q <= drop_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            tw_q   <= tw_q + AW'(grant);
            tr_q   <= tr_q + AW'(resp);
        end
    end

    always_ff @(posedge iClk or negedge inRst) begin
        if (!inRst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_pc[i]   <= '0;
                fifo_pc[i]  <= '0;
                fifo_ins[i] <= '0;
            end
        end else begin
            if (grant) tag_pc[tw_q] <= pc_q;
            if (push) begin
                fifo_pc[wptr_q[AW-1:0]]  <= tag_pc[tr_q];
                fifo_ins[wptr_q[AW-1:0]] <= iMemRData;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model with variable latency,
// expected {pc, word} queued on each grant and checked on each decoder transfer.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, gnt = 1'b1;
    logic [31:0] addr;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] ins, pc;
    logic        valid, ready = 1'b1, misalign;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mq[$];
    mreq_t       mtmp;
    int          mem_lat = 1;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] mon_e;
    int          bout = 0;
    int          xfers = 0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_ins = '0;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .iClk       (clk),
        .inRst      (rst_n),
        .oMemReq    (req),
        .oMemAddr   (addr),
        .iMemGnt    (gnt),
        .iMemRValid (rvalid),
        .iMemRData  (rdata),
        .iRedirect  (redirect),
        .iRedirectPC(rpc),
        .oINS       (ins),
        .oPC        (pc),
        .oValid     (valid),
        .iReady     (ready),
        .oMisalign  (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
    endfunction

    // In-order memory: a grant in cycle k answers in cycle k + mem_lat.
    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mtmp   = mq.pop_front();
            rvalid = 1'b1;
            rdata  = mem_data(mtmp.addr);
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        if (rst_n && req && gnt) begin
            mtmp.due  = cyc + mem_lat;
            mtmp.addr = addr;
            mq.push_back(mtmp);
        end
    end

    // Scoreboard: pop/compare on transfer, flush on redirect, push on grant.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready && !misalign) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL xfer_unexpected: got pc=%h ins=%h, none expected", pc, ins);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (pc !== mon_e || ins !== mem_data(mon_e)) begin
                        bad++;
                        $display("FAIL xfer: got pc=%h ins=%h, want pc=%h ins=%h",
                                 pc, ins, mon_e, mem_data(mon_e));
                    end
                end
                xfers++;
                last_pc  = pc;
                last_ins = ins;
            end
            if (rvalid) begin
                total++;
                if (bout == 0) begin
                    bad++;
                    $display("FAIL resp_outstanding: got response with 0 outstanding, want >0");
                end else begin
                    bout--;
                end
            end
            if (redirect) begin
                total++;
                if (req !== 1'b0) begin
                    bad++;
                    $display("FAIL req_in_redirect: got %b want 0", req);
                end
                exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                exp_pc = rpc;
`else
                exp_pc = {rpc[31:2], 2'b00};
`endif
            end else if (req && gnt) begin
                total++;
                if (addr !== exp_pc) begin
                    bad++;
                    $display("FAIL req_addr: got %h want %h", addr, exp_pc);
                end
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
                bout++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        tick();
        redirect = 1'b1;
        rpc      = target;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (req !== 1'b0 || addr !== RST_PC || valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_issue: got req=%b addr=%h valid=%b want 0 %h 0",
                     req, addr, valid, RST_PC);
        end
        total++;
        if (ins !== 32'h0 || pc !== 32'h0 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got ins=%h pc=%h mis=%b want 0 0 0", ins, pc, misalign);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        int n;
        int x0;
        logic [31:0] want;
        n = 0;
        sample();
        while (!req && n < 10) begin
            sample();
            n++;
        end
        want = RST_PC;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (req !== 1'b1 || addr !== want) begin
                bad++;
                $display("FAIL stream_addr%0d: got req=%b addr=%h want 1 %h", i, req, addr, want);
            end
            want = want + 32'd4;
            sample();
        end
        x0 = xfers;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (valid !== 1'b1) begin
                bad++;
                $display("FAIL stream_valid%0d: got %b want 1", i, valid);
            end
            sample();
        end
        total++;
        if (xfers - x0 != 6) begin
            bad++;
            $display("FAIL stream_rate: got %0d transfers want 6", xfers - x0);
        end
    endtask

    task automatic test_stall();
        int g;
        int x0;
        g = 0;
        tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (req && gnt) g++;
        end
        total++;
        if (g > DEPTH || req !== 1'b0) begin
            bad++;
            $display("FAIL stall: got grants=%0d req=%b want <=%0d and 0", g, req, DEPTH);
        end
        tick();
        ready = 1'b1;
        x0 = xfers;
        repeat (8) sample();
        total++;
        if (xfers - x0 < 5) begin
            bad++;
            $display("FAIL stall_resume: got %0d transfers want >=5", xfers - x0);
        end
    endtask

    task automatic test_redirect_latency();
        int n;
        int x0;
        mem_lat = 3;
        repeat (10) sample();
        n = 0;
        while (bout != 2 && n < 20) begin
            sample();
            n++;
        end
        total++;
        if (bout != 2) begin
            bad++;
            $display("FAIL lat3_outstanding: got %0d want 2", bout);
        end
        tick();
        redirect = 1'b1;
        rpc      = 32'h0000_0400;
        sample();
        x0 = xfers;
        tick();
        redirect = 1'b0;
        n = 0;
        while (xfers == x0 && n < 30) begin
            sample();
            n++;
        end
        total++;
        if (xfers == x0 || last_pc !== 32'h400 || last_ins !== mem_data(32'h400)) begin
            bad++;
            $display("FAIL lat3_first: got n=%0d pc=%h ins=%h want pc=00000400 ins=%h",
                     xfers - x0, last_pc, last_ins, mem_data(32'h400));
        end
        mem_lat = 1;
        repeat (10) sample();
    endtask

    task automatic test_redirect_pop_resp();
        int n;
        int x0;
        tick();
        redirect = 1'b1;
        rpc      = 32'h0000_0500;
        sample();
        total++;
        if (!(valid && ready) || rvalid !== 1'b1 || req !== 1'b0) begin
            bad++;
            $display("FAIL redir_cycle: got valid=%b rvalid=%b req=%b want 1 1 0",
                     valid, rvalid, req);
        end
        x0 = xfers;
        tick();
        redirect = 1'b0;
        n = 0;
        while (xfers == x0 && n < 20) begin
            sample();
            n++;
        end
        total++;
        if (xfers == x0 || last_pc !== 32'h500 || last_ins !== mem_data(32'h500)) begin
            bad++;
            $display("FAIL redir_first: got pc=%h ins=%h want pc=00000500 ins=%h",
                     last_pc, last_ins, mem_data(32'h500));
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [31:0] want;
        pulse_redirect(32'hFFFF_FFFC);
        want = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            sample();
            while (!(req && gnt) && n < 20) begin
                sample();
                n++;
            end
            total++;
            if (!(req && gnt) || addr !== want) begin
                bad++;
                $display("FAIL wrap%0d: got req=%b addr=%h want 1 %h", i, req, addr, want);
            end
            want = 32'h0;
        end
        repeat (6) sample();
    endtask

    task automatic test_misalign();
        int n;
        tick();
        ready    = 1'b0;
        redirect = 1'b1;
        rpc      = 32'h0000_0202;
        tick();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            sample();
            total++;
            if (misalign !== 1'b1 || valid !== 1'b1 || pc !== 32'h202 ||
                ins !== 32'h13 || req !== 1'b0) begin
                bad++;
                $display("FAIL trap_hold%0d: got mis=%b valid=%b pc=%h ins=%h req=%b want 1 1 202 13 0",
                         i, misalign, valid, pc, ins, req);
            end
        end
        tick();
        ready = 1'b1;
        sample();
        for (int i = 0; i < 3; i++) begin
            sample();
            total++;
            if (misalign !== 1'b0 || valid !== 1'b0 || req !== 1'b0) begin
                bad++;
                $display("FAIL trap_stall%0d: got mis=%b valid=%b req=%b want 0 0 0",
                         i, misalign, valid, req);
            end
        end
        pulse_redirect(32'h0000_0300);
        n = 0;
        sample();
        while (!(req && gnt) && n < 20) begin
            sample();
            n++;
        end
        total++;
        if (!(req && gnt) || addr !== 32'h300 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL trap_resume: got req=%b addr=%h mis=%b want 1 00000300 0",
                     req, addr, misalign);
        end
`else
        n = 0;
        sample();
        while (!(req && gnt) && n < 20) begin
            sample();
            n++;
        end
        total++;
        if (!(req && gnt) || addr !== 32'h200 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL align_force: got req=%b addr=%h mis=%b want 1 00000200 0",
                     req, addr, misalign);
        end
        tick();
        ready = 1'b1;
`endif
        repeat (8) sample();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_pop_resp();
        test_wrap();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
